// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-computing decoders.
// Holds the decoder state encoding and the result scaling/saturation function.
package sc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HOLD  = 2'd2
   } sc_dec_state_t;

   localparam int SC_MAX_W = 32;

   // Scales a ones count down by 'shift' bits and clamps to a 'width'-bit full scale.
   // 'width' must be at most 31.
   function automatic logic [SC_MAX_W-1:0] sc_scale_sat(
      input logic [SC_MAX_W-1:0] cnt,
      input int                  shift,
      input int                  width
   );
      logic [SC_MAX_W-1:0] scaled;
      logic [SC_MAX_W-1:0] full;
      scaled = cnt >> shift;
      full   = (SC_MAX_W'(1) << width) - SC_MAX_W'(1);
      return (scaled > full) ? full : scaled;
   endfunction

endpackage

// File: rtl/sc_window_counter.sv
// Sample and ones counters for one decode window of 2^LEN_LOG2 samples.
// done_o flags the sample that completes the window; ones_next_o includes it.
module sc_window_counter #(
   parameter int LEN_LOG2 = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              take_i,
   input  logic              bit_i,
   output logic [LEN_LOG2:0] ones_next_o,
   output logic              done_o
);

   localparam logic [LEN_LOG2:0] LAST_IDX = {1'b0, {LEN_LOG2{1'b1}}};

   logic [LEN_LOG2:0] sample_cnt_q, sample_cnt_d;
   logic [LEN_LOG2:0] ones_cnt_q, ones_cnt_d;

   assign ones_next_o = ones_cnt_q + {{LEN_LOG2{1'b0}}, bit_i};
   assign done_o      = take_i && !clr_i && (sample_cnt_q == LAST_IDX);

   always_comb begin
      sample_cnt_d = sample_cnt_q;
      ones_cnt_d   = ones_cnt_q;
      if (clr_i) begin
         sample_cnt_d = '0;
         ones_cnt_d   = '0;
      end else if (take_i) begin
         sample_cnt_d = sample_cnt_q + 1'b1;
         ones_cnt_d   = ones_next_o;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_cnt_q <= '0;
         ones_cnt_q   <= '0;
      end else begin
         sample_cnt_q <= sample_cnt_d;
         ones_cnt_q   <= ones_cnt_d;
      end
   end

endmodule

// File: rtl/sc_bitstream_decoder.sv
// Stochastic-to-binary decoder: counts ones over a 2^LEN_LOG2-sample window and
// presents the scaled probability on a valid/ready result port.
module sc_bitstream_decoder
   import sc_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int LEN_LOG2 = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             clear,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_value,
   output logic [1:0]       dbg_state
);

   if (LEN_LOG2 < WIDTH) begin : g_bad_len
      $error("sc_bitstream_decoder: LEN_LOG2 must be >= WIDTH");
   end

   // Result handshake: out_valid rises when a window completes and stays high,
   // with out_value frozen, until a cycle where out_valid && out_ready.

   sc_dec_state_t     state_q, state_d;
   logic [WIDTH-1:0]  out_value_q, out_value_d;
   logic              cnt_clr;
   logic              take;
   logic              done;
   logic [LEN_LOG2:0] ones_next;

   // Counters are held clear in IDLE, so the start cycle is never a sample.
   assign cnt_clr = clear || (state_q == IDLE);
   assign take    = (state_q == COUNT) && in_valid && !clear;

   sc_window_counter #(
      .LEN_LOG2(LEN_LOG2)
   ) u_window_counter (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (cnt_clr),
      .take_i     (take),
      .bit_i      (in_bit),
      .ones_next_o(ones_next),
      .done_o     (done)
   );

   always_comb begin
      state_d     = state_q;
      out_value_d = out_value_q;
      if (clear) begin
         state_d     = IDLE;
         out_value_d = '0;
      end else begin
         case (state_q)
            IDLE:  if (start) state_d = COUNT;
            COUNT: begin
               if (done) begin
                  state_d     = HOLD;
                  out_value_d = WIDTH'(sc_scale_sat(SC_MAX_W'(ones_next), LEN_LOG2 - WIDTH, WIDTH));
               end
            end
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         out_value_q <= '0;
      end else begin
         state_q     <= state_d;
         out_value_q <= out_value_d;
      end
   end

   assign busy      = (state_q == COUNT);
   assign out_valid = (state_q == HOLD);
   assign out_value = out_value_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sc_bitstream_decoder.sv
// Directed bench for sc_bitstream_decoder (WIDTH=8, LEN_LOG2=8).
// Expected results are hand-computed constants; a tiny LFSR feeds the loopback cases.
module tb_sc_bitstream_decoder;

   localparam int WIDTH    = 8;
   localparam int LEN_LOG2 = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             clear;
   logic             in_valid;
   logic             in_bit;
   logic             out_ready;
   logic             busy;
   logic             out_valid;
   logic [WIDTH-1:0] out_value;
   logic [1:0]       dbg_state;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]       lfsr;
   logic [WIDTH-1:0] v;

   always #5 clk = ~clk;

   sc_bitstream_decoder #(
      .WIDTH   (WIDTH),
      .LEN_LOG2(LEN_LOG2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .clear    (clear),
      .in_valid (in_valid),
      .in_bit   (in_bit),
      .busy     (busy),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_value(out_value),
      .dbg_state(dbg_state)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts a window and feeds samples until out_valid. pat: 0 ones, 1 zeros,
   // 2 alternating 1,0, 3 pattern 1,0,0,0, 4 LFSR > thr. Invalid cycles carry in_bit=1.
   task automatic run_window(input string tag, input int pat, input logic [7:0] thr,
                             input bit toggle, input int exp_lat, output logic [WIDTH-1:0] val);
      int s;
      int lat;
      s   = 0;
      lat = -1;
      lfsr = 8'h01;
      start = 1'b1;
      step();
      start = 1'b0;
      check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      for (int k = 1; k <= 600; k++) begin
         in_valid = toggle ? (k % 2 == 0) : 1'b1;
         if (!in_valid) begin
            in_bit = 1'b1;
         end else begin
            case (pat)
               0:       in_bit = 1'b1;
               1:       in_bit = 1'b0;
               2:       in_bit = (s % 2 == 0);
               3:       in_bit = (s % 4 == 0);
               default: begin
                  in_bit = (lfsr > thr);
                  lfsr   = (lfsr >> 1) ^ (lfsr[0] ? 8'hB8 : 8'h00);
               end
            endcase
            s++;
         end
         step();
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      in_valid = 1'b0;
      in_bit   = 1'b0;
      check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      val = out_value;
   endtask

   task automatic accept(input string tag, input logic [WIDTH-1:0] exp_val);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_eq({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_idle_state"}, 32'(dbg_state), 32'd0);
      check_eq({tag, "_idle_keep"}, 32'(out_value), 32'(exp_val));
   endtask

   task automatic partial_window(input int n);
      start = 1'b1;
      step();
      start    = 1'b0;
      in_valid = 1'b1;
      in_bit   = 1'b1;
      for (int k = 0; k < n; k++) step();
      in_valid = 1'b0;
      in_bit   = 1'b0;
   endtask

   task automatic check_zeroed(input string tag);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_value"}, 32'(out_value), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_bit    = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      check_zeroed("reset");
      check_eq("reset_state", 32'(dbg_state), 32'd0);
      rst = 1'b0;
      step();

      run_window("ones", 0, 8'd0, 1'b0, 256, v);
      check_eq("ones_value", 32'(v), 32'd255);
      accept("ones", 8'd255);

      run_window("zeros", 1, 8'd0, 1'b0, 256, v);
      check_eq("zeros_value", 32'(v), 32'd0);
      accept("zeros", 8'd0);

      run_window("alt", 2, 8'd0, 1'b0, 256, v);
      check_eq("alt_value", 32'(v), 32'd128);
      accept("alt", 8'd128);

      run_window("quarter", 3, 8'd0, 1'b0, 256, v);
      check_eq("quarter_value", 32'(v), 32'd64);
      accept("quarter", 8'd64);

      run_window("tog_ones", 0, 8'd0, 1'b1, 512, v);
      check_eq("tog_ones_value", 32'(v), 32'd255);
      accept("tog_ones", 8'd255);

      run_window("tog_zeros", 1, 8'd0, 1'b1, 512, v);
      check_eq("tog_zeros_value", 32'(v), 32'd0);
      accept("tog_zeros", 8'd0);

      // Stall the consumer for 20 cycles with a stray start in the middle.
      run_window("hold", 3, 8'd0, 1'b0, 256, v);
      for (int i = 0; i < 20; i++) begin
         start = (i == 5);
         step();
         check_eq("hold_valid", 32'(out_valid), 32'd1);
         check_eq("hold_value", 32'(out_value), 32'd64);
         check_eq("hold_busy", 32'(busy), 32'd0);
      end
      start = 1'b0;
      accept("hold", 8'd64);

      partial_window(100);
      check_eq("rst_abort_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      step();
      check_zeroed("rst_abort");
      rst = 1'b0;
      step();
      run_window("after_rst", 0, 8'd0, 1'b0, 256, v);
      check_eq("after_rst_value", 32'(v), 32'd255);
      accept("after_rst", 8'd255);

      partial_window(100);
      check_eq("clr_abort_busy_before", 32'(busy), 32'd1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check_zeroed("clr_abort");
      run_window("after_clr", 2, 8'd0, 1'b0, 256, v);
      check_eq("after_clr_value", 32'(v), 32'd128);
      accept("after_clr", 8'd128);

      run_window("lfsr127", 4, 8'd127, 1'b0, 256, v);
      check_eq("lfsr127_in_range", 32'(v >= 8'd112 && v <= 8'd144), 32'd1);
      accept("lfsr127", v);

      run_window("lfsr0", 4, 8'd0, 1'b0, 256, v);
      check_eq("lfsr0_high", 32'(v >= 8'd250), 32'd1);
      accept("lfsr0", v);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
